mmio_pwm_bank: RTL and testbench
================================

Name: mmio_pwm_bank

Overview:
- Memory-mapped bank of NUM_CH pulse-width-modulated outputs. It generalises the fixed single LED/RGB drive into a parametrised peripheral.
- Sits beside the data memory on the core's load/store bus and uses the same signalling: write_mem, funct3, split read/write addresses, and registered read data.
- The top-level address decoder routes accesses in the window [BASE_ADDR, BASE_ADDR+0xFF] here.
- Outputs drive LEDs directly, e.g. NUM_CH=4 for LED, red, green and blue.

Parameters:
- NUM_CH, 4, number of PWM channels (1..8).
- CNT_W, 16, width of the period counter, duty registers and period register.
- PRE_W, 16, width of the prescaler.
- BASE_ADDR, 32'hFFFF_FF00, byte base address of the register window (256-byte aligned).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- write_mem  in  1  write strobe.
- funct3  in  3  access size: 000 byte, 001 half, 010 word; other codes ignored.
- write_address  in  32  byte address for writes.
- write_data  in  32  store data, right-aligned as produced by the core.
- read_address  in  32  byte address for reads.
- read_data  out  32  register contents, valid one cycle after read_address.
- pwm_out  out  NUM_CH  registered PWM outputs.

Behaviour:
- Register map (offsets; every register is word-aligned):
  - 0x00 CTRL: bit0 enable. Other bits read 0.
  - 0x04 PRESCALE: PRE_W bits.
  - 0x08 PERIOD: CNT_W bits.
  - 0x0C STATUS: bits[CNT_W-1:0] live period count. Read-only.
  - 0x10+4*i DUTY[i], i < NUM_CH.
- Address handling:
  - Addresses outside the window or unmapped within it: writes ignored, reads return 0.
  - Register bits beyond a register's width read 0 and ignore writes.
- Write lane rules:
  - SB writes byte write_data[7:0] into lane address[1:0].
  - SH writes write_data[15:0] into half address[1]. If address[0]=1 the write is ignored.
  - SW requires address[1:0]=00, otherwise the write is ignored.
- Read: read_data is registered with 1-cycle latency and always returns the full word; the core extracts the bytes it needs. A same-cycle write and read of the same register returns the pre-write value.
- Timebase:
  - Prescaler counts 0..PRESCALE. It emits tick when count==PRESCALE and then wraps to 0. PRESCALE=0 gives a tick every cycle.
  - Period counter advances on each tick over 0..PERIOD_act. A wrap event occurs on the tick where count==PERIOD_act; the counter then returns to 0.
  - Both counters are held at 0 while enable=0.
- Shadowing:
  - PERIOD and DUTY writes land in shadow registers.
  - Active copies (PERIOD_act, DUTY_act[i]) load from the shadows on a wrap event, or immediately while enable=0. This gives glitch-free updates.
  - If PERIOD is written below the live count, the current period still completes at the old PERIOD_act.
- Output: pwm_out[i] is registered as enable && (count < DUTY_act[i]). This is 1 cycle after the count changes.
  - DUTY_act = 0 gives constant 0.
  - DUTY_act > PERIOD_act gives constant 1.
  - PERIOD_act = 0 gives a 1-count period.
- Reset mid-operation: all registers, shadows, active copies, counters, read_data and pwm_out go to 0 on the next edge. Any in-flight write that cycle is discarded.

Optional Feature:
- Macro: MMIO_PWM_FADE_EN.
- When defined:
  - Adds TARGET[i] registers at offset 0x40+4*i, and CTRL bit1 fade_en.
  - While fade_en=1, on each wrap event DUTY_act[i] steps by 1 toward TARGET[i] and stops when equal.
  - DUTY shadow writes are still accepted but are not applied while fade_en=1.
  - With fade_en=0, behaviour is identical to the non-fade build.
- When undefined: the 0x40+ offsets are unmapped (read 0), CTRL bit1 reads 0, and no fade logic is synthesised.

Decomposition:
- Package mmio_pwm_pkg holds:
  - register offset localparams (CTRL, PRESCALE, PERIOD, STATUS, DUTY_BASE, TARGET_BASE);
  - funct3 encodings FUNCT3_B/H/W;
  - the CTRL bit indices.
- Sub-module pwm_timebase contains the prescaler and period counter, with outputs tick, wrap and count. The channel compare logic and register file stay in mmio_pwm_bank.

Test Plan:
- Reset then read all offsets: every register reads 0, pwm_out=0; an unmapped offset 0x3C reads 0.
- Write PRESCALE=0, PERIOD=9, DUTY[0]=3, CTRL=1: pwm_out[0] is high 3 cycles and low 7 cycles, repeating with period 10. DUTY[1]=0 gives a constant-low output; DUTY[2]=12 gives a constant-high output.
- SB 0xAB to DUTY[0]+1, then SH 0x1234 to PERIOD+0, then SH to PERIOD+1 with address[0]=1: DUTY[0] reads 0x0000AB03, PERIOD reads 0x1234, and the misaligned SH has no effect.
- While running with PERIOD=9, write DUTY[0]=7 at count 4: the duty stays 3 until the wrap, and the next period is high for 7 cycles.
- Assert reset while counting with pwm_out high: on the next edge pwm_out=0, STATUS=0 and CTRL=0.
- With MMIO_PWM_FADE_EN defined: DUTY_act=0, TARGET[0]=3, fade_en=1, PERIOD=9 gives high times of 1, 2, 3, 3... over successive periods.

Source files
------------

// File: rtl/mmio_pwm_pkg.sv
// Shared definitions for the memory-mapped PWM bank.
// Optional fade feature is selected with the MMIO_PWM_FADE_EN macro.
package mmio_pwm_pkg;

    localparam int unsigned WORD_W = 32;

    // Register offsets within the 256-byte window
    localparam logic [7:0] OFF_CTRL        = 8'h00;
    localparam logic [7:0] OFF_PRESCALE    = 8'h04;
    localparam logic [7:0] OFF_PERIOD      = 8'h08;
    localparam logic [7:0] OFF_STATUS      = 8'h0C;
    localparam logic [7:0] OFF_DUTY_BASE   = 8'h10;
    localparam logic [7:0] OFF_TARGET_BASE = 8'h40;

    // Load/store access sizes
    localparam logic [2:0] FUNCT3_B = 3'b000;
    localparam logic [2:0] FUNCT3_H = 3'b001;
    localparam logic [2:0] FUNCT3_W = 3'b010;

    // CTRL bit positions
    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_FADE_BIT   = 1;

    // Store payload after lane steering: byte enables plus replicated data
    typedef struct packed {
        logic [3:0]        be;
        logic [WORD_W-1:0] data;
    } wr_lanes_t;

    // Steer right-aligned store data onto byte lanes; illegal alignments yield no enables
    function automatic wr_lanes_t steer_write(input logic [2:0] f3,
                                              input logic [1:0] lo,
                                              input logic [WORD_W-1:0] wd);
        wr_lanes_t r;
        r.be   = 4'b0000;
        r.data = wd;
        case (f3)
            FUNCT3_B: begin
                r.be   = 4'b0001 << lo;
                r.data = {4{wd[7:0]}};
            end
            FUNCT3_H: begin
                if (!lo[0]) begin
                    r.be = lo[1] ? 4'b1100 : 4'b0011;
                end
                r.data = {2{wd[15:0]}};
            end
            FUNCT3_W: begin
                if (lo == 2'b00) begin
                    r.be = 4'b1111;
                end
            end
            default: r.be = 4'b0000;
        endcase
        return r;
    endfunction

    // Merge enabled byte lanes into an existing register word
    function automatic logic [WORD_W-1:0] apply_lanes(input logic [WORD_W-1:0] old_val,
                                                      input wr_lanes_t w);
        logic [WORD_W-1:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (w.be[b]) begin
                r[8*b +: 8] = w.data[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_pwm_bank_timebase.sv
// Prescaler and period counter shared by all PWM channels.
module pwm_timebase
    import mmio_pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PRE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [PRE_W-1:0] prescale,
    input  logic [CNT_W-1:0] period_act,
    output logic             tick,
    output logic             wrap,
    output logic [CNT_W-1:0] count
);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Tick/wrap detection and counter advance; both counters parked at 0 when disabled.
    // >= on the prescaler keeps it from running away if PRESCALE is lowered mid-count.
    always_comb begin
        tick    = enable && (pre_q >= prescale);
        wrap    = tick && (count_q == period_act);
        pre_d   = pre_q;
        count_d = count_q;
        if (!enable) begin
            pre_d   = '0;
            count_d = '0;
        end else begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                count_d = wrap ? '0 : count_q + CNT_W'(1);
            end
        end
    end

    // Counter state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            count_q <= '0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mmio_pwm_bank.sv
// Memory-mapped bank of NUM_CH shadowed PWM outputs on the load/store bus.
// Define MMIO_PWM_FADE_EN to add TARGET registers and CTRL.fade_en duty stepping.
module mmio_pwm_bank
    import mmio_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PRE_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_mem,
    input  logic [2:0]        funct3,
    input  logic [31:0]       write_address,
    input  logic [31:0]       write_data,
    input  logic [31:0]       read_address,
    output logic [31:0]       read_data,
    output logic [NUM_CH-1:0] pwm_out
);

    // Programmer-visible and active state
    logic             enable_q, enable_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [CNT_W-1:0] period_sh_q, period_sh_d;
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic [CNT_W-1:0] duty_sh_q  [NUM_CH];
    logic [CNT_W-1:0] duty_sh_d  [NUM_CH];
    logic [CNT_W-1:0] duty_act_q [NUM_CH];
    logic [CNT_W-1:0] duty_act_d [NUM_CH];
`ifdef MMIO_PWM_FADE_EN
    logic             fade_en_q, fade_en_d;
    logic [CNT_W-1:0] target_q [NUM_CH];
    logic [CNT_W-1:0] target_d [NUM_CH];
`endif
    logic [31:0]       read_data_q, read_data_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;

    // Timebase interface
    logic             tb_tick;
    logic             tb_wrap;
    logic [CNT_W-1:0] tb_count;

    // Bus decode
    wr_lanes_t   wr_c;
    logic        wr_hit_c;
    logic [7:0]  wr_off_c;
    logic [31:0] wr_word_c;
    logic        rd_hit_c;
    logic [7:0]  rd_off_c;
    logic        wrap_evt_c;
    logic        load_c;

    assign wr_c     = steer_write(funct3, write_address[1:0], write_data);
    assign wr_hit_c = write_mem && (write_address[31:8] == BASE_ADDR[31:8]) && (wr_c.be != 4'b0000);
    assign wr_off_c = {write_address[7:2], 2'b00};
    assign rd_hit_c = (read_address[31:8] == BASE_ADDR[31:8]);
    assign rd_off_c = read_address[7:0] & 8'hFC;

    // Current contents of the register at a word offset; unmapped offsets read 0
    function automatic logic [31:0] reg_value(input logic [7:0] off);
        logic [31:0] v;
        v = '0;
        if (off == OFF_CTRL) begin
            v[CTRL_ENABLE_BIT] = enable_q;
`ifdef MMIO_PWM_FADE_EN
            v[CTRL_FADE_BIT] = fade_en_q;
`endif
        end
        if (off == OFF_PRESCALE) v = 32'(prescale_q);
        if (off == OFF_PERIOD)   v = 32'(period_sh_q);
        if (off == OFF_STATUS)   v = 32'(tb_count);
        for (int i = 0; i < NUM_CH; i++) begin
            if (off == OFF_DUTY_BASE + 8'(4 * i)) v = 32'(duty_sh_q[i]);
`ifdef MMIO_PWM_FADE_EN
            if (off == OFF_TARGET_BASE + 8'(4 * i)) v = 32'(target_q[i]);
`endif
        end
        return v;
    endfunction

    // Read-modify-write word for stores and registered read mux (pre-write values)
    always_comb begin
        wr_word_c   = apply_lanes(reg_value(wr_off_c), wr_c);
        read_data_d = rd_hit_c ? reg_value(rd_off_c) : '0;
    end

    // Register file writes; bits beyond each register's width are dropped
    always_comb begin
        enable_d    = enable_q;
        prescale_d  = prescale_q;
        period_sh_d = period_sh_q;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_sh_d[i] = duty_sh_q[i];
        end
`ifdef MMIO_PWM_FADE_EN
        fade_en_d = fade_en_q;
        for (int i = 0; i < NUM_CH; i++) begin
            target_d[i] = target_q[i];
        end
`endif
        if (wr_hit_c) begin
            if (wr_off_c == OFF_CTRL) begin
                enable_d = wr_word_c[CTRL_ENABLE_BIT];
`ifdef MMIO_PWM_FADE_EN
                fade_en_d = wr_word_c[CTRL_FADE_BIT];
`endif
            end
            if (wr_off_c == OFF_PRESCALE) prescale_d  = wr_word_c[PRE_W-1:0];
            if (wr_off_c == OFF_PERIOD)   period_sh_d = wr_word_c[CNT_W-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_off_c == OFF_DUTY_BASE + 8'(4 * i)) duty_sh_d[i] = wr_word_c[CNT_W-1:0];
`ifdef MMIO_PWM_FADE_EN
                if (wr_off_c == OFF_TARGET_BASE + 8'(4 * i)) target_d[i] = wr_word_c[CNT_W-1:0];
`endif
            end
        end
    end

    // Shadow-to-active transfer: at period end, or continuously while disabled
    always_comb begin
        wrap_evt_c   = tb_wrap && tb_tick;
        load_c       = !enable_q || wrap_evt_c;
        period_act_d = load_c ? period_sh_q : period_act_q;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_act_d[i] = duty_act_q[i];
`ifdef MMIO_PWM_FADE_EN
            if (fade_en_q) begin
                if (wrap_evt_c && (duty_act_q[i] < target_q[i])) begin
                    duty_act_d[i] = duty_act_q[i] + CNT_W'(1);
                end else if (wrap_evt_c && (duty_act_q[i] > target_q[i])) begin
                    duty_act_d[i] = duty_act_q[i] - CNT_W'(1);
                end
            end else if (load_c) begin
                duty_act_d[i] = duty_sh_q[i];
            end
`else
            if (load_c) begin
                duty_act_d[i] = duty_sh_q[i];
            end
`endif
        end
    end

    // Channel compare against the live count
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = enable_q && (tb_count < duty_act_q[i]);
        end
    end

    // State registers; reset wins over any in-flight store
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q     <= 1'b0;
            prescale_q   <= '0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
`ifdef MMIO_PWM_FADE_EN
            fade_en_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= '0;
            end
`endif
            read_data_q <= '0;
            pwm_q       <= '0;
        end else begin
            enable_q     <= enable_d;
            prescale_q   <= prescale_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i]  <= duty_sh_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
`ifdef MMIO_PWM_FADE_EN
            fade_en_q <= fade_en_d;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= target_d[i];
            end
`endif
            read_data_q <= read_data_d;
            pwm_q       <= pwm_d;
        end
    end

    pwm_timebase #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable_q),
        .prescale   (prescale_q),
        .period_act (period_act_q),
        .tick       (tb_tick),
        .wrap       (tb_wrap),
        .count      (tb_count)
    );

    assign read_data = read_data_q;
    assign pwm_out   = pwm_q;

endmodule

// File: tb/tb_mmio_pwm_bank.sv
// Self-checking bench for mmio_pwm_bank: register table, randomized register
// traffic against a byte-lane model, and PWM waveforms against closed-form timing.
module tb_mmio_pwm_bank;
    import mmio_pwm_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PRE_W  = 16;
    localparam logic [31:0] BASE   = 32'hFFFF_FF00;

    logic              clk = 1'b0;
    logic              reset;
    logic              write_mem;
    logic [2:0]        funct3;
    logic [31:0]       write_address;
    logic [31:0]       write_data;
    logic [31:0]       read_address;
    logic [31:0]       read_data;
    logic [NUM_CH-1:0] pwm_out;

    always #5 clk = ~clk;

    mmio_pwm_bank #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .PRE_W     (PRE_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_mem     (write_mem),
        .funct3        (funct3),
        .write_address (write_address),
        .write_data    (write_data),
        .read_address  (read_address),
        .read_data     (read_data),
        .pwm_out       (pwm_out)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] mdl [64];
    int unsigned duty [NUM_CH];

    typedef struct {
        string       name;
        logic        do_wr;
        logic [31:0] wa;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] ra;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input string nm, input logic w, input logic [31:0] wa,
                                input logic [2:0] f3, input logic [31:0] wd,
                                input logic [31:0] ra, input logic [31:0] ex);
        vec_t v;
        v.name = nm; v.do_wr = w; v.wa = wa; v.f3 = f3; v.wd = wd; v.ra = ra; v.exp_rd = ex;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    task automatic idle_bus();
        write_mem     = 1'b0;
        funct3        = FUNCT3_W;
        write_address = 32'h0;
        write_data    = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        write_mem     = 1'b1;
        write_address = a;
        write_data    = d;
        funct3        = f3;
        @(posedge clk); #1;
        write_mem = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        read_address = a;
        @(posedge clk); #1;
        d = read_data;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        idle_bus();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
    endtask

    // Writable bits of each register word
    function automatic logic [31:0] wmask(input int unsigned idx);
        logic [31:0] m;
        m = 32'h0;
        if (idx == 0) begin
`ifdef MMIO_PWM_FADE_EN
            m = 32'h3;
`else
            m = 32'h1;
`endif
        end
        if (idx == 1) m = 32'((64'd1 << PRE_W) - 1);
        if (idx == 2) m = 32'((64'd1 << CNT_W) - 1);
        if (idx >= 4 && idx < 4 + NUM_CH) m = 32'((64'd1 << CNT_W) - 1);
`ifdef MMIO_PWM_FADE_EN
        if (idx >= 16 && idx < 16 + NUM_CH) m = 32'((64'd1 << CNT_W) - 1);
`endif
        return m;
    endfunction

    // Store semantics expressed as byte arithmetic on the addressed word
    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        int unsigned idx;
        int unsigned lo;
        logic [31:0] cur;
        logic        ok;
        if (a[31:8] != BASE[31:8]) return;
        idx = int'(a[7:2]);
        lo  = int'(a[1:0]);
        cur = mdl[idx];
        ok  = 1'b1;
        case (f3)
            3'b000: cur = (cur & ~(32'hFF << (8 * lo))) | ({24'h0, d[7:0]} << (8 * lo));
            3'b001: if (lo % 2 == 1) ok = 1'b0;
                    else cur = (cur & ~(32'hFFFF << (8 * lo))) | ({16'h0, d[15:0]} << (8 * lo));
            3'b010: if (lo != 0) ok = 1'b0; else cur = d;
            default: ok = 1'b0;
        endcase
        if (ok) mdl[idx] = cur & wmask(idx);
    endtask

    task automatic run_table();
        logic [31:0] got;
        tbl.delete();
        tbl.push_back(mk("rst_ctrl",    1'b0, 0, 0, 0, BASE + 32'h00, 32'h0));
        tbl.push_back(mk("rst_pre",     1'b0, 0, 0, 0, BASE + 32'h04, 32'h0));
        tbl.push_back(mk("rst_period",  1'b0, 0, 0, 0, BASE + 32'h08, 32'h0));
        tbl.push_back(mk("rst_status",  1'b0, 0, 0, 0, BASE + 32'h0C, 32'h0));
        tbl.push_back(mk("rst_duty0",   1'b0, 0, 0, 0, BASE + 32'h10, 32'h0));
        tbl.push_back(mk("rst_duty1",   1'b0, 0, 0, 0, BASE + 32'h14, 32'h0));
        tbl.push_back(mk("rst_duty2",   1'b0, 0, 0, 0, BASE + 32'h18, 32'h0));
        tbl.push_back(mk("rst_duty3",   1'b0, 0, 0, 0, BASE + 32'h1C, 32'h0));
        tbl.push_back(mk("rst_unmap3c", 1'b0, 0, 0, 0, BASE + 32'h3C, 32'h0));
        tbl.push_back(mk("rst_off40",   1'b0, 0, 0, 0, BASE + 32'h40, 32'h0));
        tbl.push_back(mk("sw_duty0",    1'b1, BASE + 32'h10, FUNCT3_W, 32'h0000_0003, BASE + 32'h10, 32'h0000_0003));
        tbl.push_back(mk("sb_duty0_b1", 1'b1, BASE + 32'h11, FUNCT3_B, 32'h1234_56AB, BASE + 32'h10, 32'h0000_AB03));
        tbl.push_back(mk("sh_period",   1'b1, BASE + 32'h08, FUNCT3_H, 32'hFFFF_1234, BASE + 32'h08, 32'h0000_1234));
        tbl.push_back(mk("sh_misalign", 1'b1, BASE + 32'h09, FUNCT3_H, 32'h0000_5678, BASE + 32'h08, 32'h0000_1234));
        tbl.push_back(mk("sh_upper",    1'b1, BASE + 32'h0A, FUNCT3_H, 32'h0000_9999, BASE + 32'h08, 32'h0000_1234));
        tbl.push_back(mk("sw_pre_full", 1'b1, BASE + 32'h04, FUNCT3_W, 32'hFFFF_FFFF, BASE + 32'h04, 32'h0000_FFFF));
        tbl.push_back(mk("sw_misalign", 1'b1, BASE + 32'h06, FUNCT3_W, 32'h0000_0000, BASE + 32'h04, 32'h0000_FFFF));
        tbl.push_back(mk("f3_illegal",  1'b1, BASE + 32'h04, 3'b011,   32'h0000_0000, BASE + 32'h04, 32'h0000_FFFF));
        tbl.push_back(mk("ctrl_hibits", 1'b1, BASE + 32'h00, FUNCT3_W, 32'hFFFF_FFFC, BASE + 32'h00, 32'h0));
        tbl.push_back(mk("status_ro",   1'b1, BASE + 32'h0C, FUNCT3_W, 32'h0000_0055, BASE + 32'h0C, 32'h0));
        tbl.push_back(mk("out_win_wr",  1'b1, 32'hFFFF_FE10, FUNCT3_W, 32'h0000_0001, BASE + 32'h10, 32'h0000_AB03));
        tbl.push_back(mk("out_win_rd",  1'b0, 0, 0, 0, 32'h0000_0010, 32'h0));
        tbl.push_back(mk("sb_beyond",   1'b1, BASE + 32'h1F, FUNCT3_B, 32'h0000_007F, BASE + 32'h1C, 32'h0));
        tbl.push_back(mk("sw_duty3",    1'b1, BASE + 32'h1C, FUNCT3_W, 32'h0000_DEAD, BASE + 32'h1C, 32'h0000_DEAD));
        tbl.push_back(mk("unmap_20",    1'b1, BASE + 32'h20, FUNCT3_W, 32'h1111_1111, BASE + 32'h20, 32'h0));
        tbl.push_back(mk("pre_clear",   1'b1, BASE + 32'h04, FUNCT3_W, 32'h0000_0000, BASE + 32'h04, 32'h0));
        check("rst_pwm", 32'(pwm_out), 32'h0);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].do_wr) wr(tbl[i].wa, tbl[i].wd, tbl[i].f3);
            rd(tbl[i].ra, got);
            check(tbl[i].name, got, tbl[i].exp_rd);
        end
    endtask

    // Store and load to the same register in one cycle: load sees the old value
    task automatic same_cycle_rw();
        write_mem     = 1'b1;
        write_address = BASE + 32'h14;
        write_data    = 32'h0000_0077;
        funct3        = FUNCT3_W;
        read_address  = BASE + 32'h14;
        @(posedge clk); #1;
        write_mem = 1'b0;
        check("rw_same_old", read_data, 32'h0);
        @(posedge clk); #1;
        check("rw_same_new", read_data, 32'h0000_0077);
    endtask

    task automatic random_reg_test();
        int unsigned idx;
        logic [1:0]  lo;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] got;
        reset_dut();
        for (int i = 0; i < 24; i++) begin
            rd(BASE + 32'(4 * i), got);
            check($sformatf("rst2_word%0d", i), got, 32'h0);
        end
        for (int n = 0; n < 150; n++) begin
            idx = $urandom_range(1, 23);
            lo  = 2'($urandom_range(0, 3));
            f3  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a   = BASE + 32'(4 * idx) + 32'(lo);
            if ($urandom_range(0, 7) == 0) a[31:8] = 24'h00ABCD;
            d   = $urandom;
            wr(a, d, f3);
            model_write(a, d, f3);
            rd(BASE + 32'(4 * idx), got);
            check($sformatf("rnd_reg%0d_off%02h", n, 4 * idx), got, mdl[idx]);
        end
    endtask

    // Fixed scenario: period 10, mid-period duty change, then PERIOD shrunk below the live count
    function automatic int unsigned tp_cnt(input int unsigned t);
        return (t < 70) ? (t % 10) : ((t - 70) % 5);
    endfunction

    function automatic int unsigned tp_duty0(input int unsigned t);
        return (t < 40) ? 3 : ((t < 70) ? 7 : 2);
    endfunction

    task automatic test_plan_pwm();
        logic [NUM_CH-1:0] e;
        int unsigned c;
        int unsigned waited;
        logic [31:0] got;
        reset_dut();
        wr(BASE + 32'h04, 32'd0,  FUNCT3_W);
        wr(BASE + 32'h08, 32'd9,  FUNCT3_W);
        wr(BASE + 32'h10, 32'd3,  FUNCT3_W);
        wr(BASE + 32'h14, 32'd0,  FUNCT3_W);
        wr(BASE + 32'h18, 32'd12, FUNCT3_W);
        wr(BASE + 32'h1C, 32'd10, FUNCT3_W);
        wr(BASE + 32'h00, 32'd1,  FUNCT3_W);
        check("tp_pwm_k0", 32'(pwm_out), 32'h0);
        for (int k = 1; k <= 100; k++) begin
            if (k == 35)      wr(BASE + 32'h10, 32'd7, FUNCT3_W);
            else if (k == 62) wr(BASE + 32'h10, 32'd2, FUNCT3_W);
            else if (k == 68) wr(BASE + 32'h08, 32'd4, FUNCT3_W);
            else begin
                @(posedge clk); #1;
            end
            c = tp_cnt(k - 1);
            e[0] = (c < tp_duty0(k - 1));
            e[1] = 1'b0;
            e[2] = (c < 12);
            e[3] = (c < 10);
            check($sformatf("tp_pwm_k%0d", k), 32'(pwm_out), 32'(e));
        end
        // Reset while channel 0 is high, with a store in flight
        waited = 0;
        while (pwm_out[0] !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("rst_mid_wait_high", 32'(pwm_out[0]), 32'h1);
        reset         = 1'b1;
        write_mem     = 1'b1;
        write_address = BASE + 32'h10;
        write_data    = 32'd5;
        funct3        = FUNCT3_W;
        read_address  = BASE + 32'h0C;
        @(posedge clk); #1;
        reset     = 1'b0;
        write_mem = 1'b0;
        check("rst_mid_pwm", 32'(pwm_out), 32'h0);
        check("rst_mid_rdata", read_data, 32'h0);
        rd(BASE + 32'h0C, got); check("rst_mid_status", got, 32'h0);
        rd(BASE + 32'h00, got); check("rst_mid_ctrl", got, 32'h0);
        rd(BASE + 32'h10, got); check("rst_mid_duty0", got, 32'h0);
        rd(BASE + 32'h08, got); check("rst_mid_period", got, 32'h0);
        check("rst_mid_pwm_after", 32'(pwm_out), 32'h0);
    endtask

    // Random configurations: count(t) = floor(t/(P+1)) mod (N+1), pwm lags count by one cycle
    task automatic random_pwm_test();
        int unsigned p;
        int unsigned n;
        int unsigned len;
        int unsigned c;
        logic [NUM_CH-1:0] e;
        for (int it = 0; it < 8; it++) begin
            p = $urandom_range(0, 2);
            n = $urandom_range(0, 6);
            wr(BASE + 32'h00, 32'd0, FUNCT3_W);
            wr(BASE + 32'h04, 32'(p), FUNCT3_W);
            wr(BASE + 32'h08, 32'(n), FUNCT3_W);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                duty[ch] = $urandom_range(0, n + 2);
                wr(BASE + 32'h10 + 32'(4 * ch), 32'(duty[ch]), FUNCT3_W);
            end
            read_address = BASE + 32'h0C;
            wr(BASE + 32'h00, 32'd1, FUNCT3_W);
            len = 2 * (p + 1) * (n + 1) + 2;
            for (int k = 1; k <= len; k++) begin
                @(posedge clk); #1;
                c = ((k - 1) / (p + 1)) % (n + 1);
                for (int ch = 0; ch < NUM_CH; ch++) e[ch] = (c < duty[ch]);
                check($sformatf("rp%0d_pwm_k%0d", it, k), 32'(pwm_out), 32'(e));
                check($sformatf("rp%0d_status_k%0d", it, k), read_data, 32'(c));
            end
        end
    endtask

    initial begin
        read_address = 32'h0;
        reset_dut();
        run_table();
        same_cycle_rw();
        random_reg_test();
        test_plan_pwm();
        random_pwm_test();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
